// File: rtl/y86_seq_controller.sv
// Stage sequencer for the sequential Y86-64 core: owns the PC, issues one-cycle
// stage enables, runs the data-memory handshake and raises the Y86 status code.
module y86_seq_controller #(
    parameter logic [63:0] RESET_PC    = 64'd0,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    output logic [63:0]      PC,
    input  logic [3:0]       iCode,
    input  logic [63:0]      ValC,
    input  logic [63:0]      ValP,
    input  logic             Instr_Valid,
    input  logic             imem_error,
    input  logic             Cnd,
    input  logic [63:0]      valM,
    input  logic             dmem_error,
    output logic             dec_en,
    output logic             exe_en,
    output logic             wb_en,
    output logic             mem_req,
    input  logic             mem_ready,
    output logic [2:0]       stat,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEMORY  = 3'd4,
        S_WB      = 3'd5,
        S_PCUPD   = 3'd6,
        S_HALTED  = 3'd7
    } state_t;

    state_t            state_q;
    state_t            state_n;
    logic [2:0]        stat_n;
    logic [3:0]        icode_q;
    logic              cnd_q;
    logic [63:0]       valm_q;
    logic [WAIT_W-1:0] wait_q;
    logic              is_mem_c;
    logic [63:0]       next_pc_c;

    assign state = state_q;

    // rmmovq, mrmovq, call, ret, pushq, popq touch data memory
    always_comb begin
        is_mem_c = 1'b0;
        case (icode_q)
            4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: is_mem_c = 1'b1;
            default:                            is_mem_c = 1'b0;
        endcase
    end

    always_comb begin
        next_pc_c = ValP;
        case (icode_q)
            4'h7:    next_pc_c = cnd_q ? ValC : ValP;
            4'h8:    next_pc_c = ValC;
            4'h9:    next_pc_c = valm_q;
            default: next_pc_c = ValP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state and status decode
    always_comb begin
        state_n = state_q;
        stat_n  = stat;
        case (state_q)
            S_IDLE: begin
                if (run) state_n = S_FETCH;
            end
            S_FETCH: begin
                state_n = S_DECODE;
            end
            S_DECODE: begin
                if (imem_error) begin
                    state_n = S_HALTED;
                    stat_n  = STAT_ADR;
                end else if (!Instr_Valid) begin
                    state_n = S_HALTED;
                    stat_n  = STAT_INS;
                end else if (iCode == 4'h0) begin
                    state_n = S_HALTED;
                    stat_n  = STAT_HLT;
                end else begin
                    state_n = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                state_n = is_mem_c ? S_MEMORY : S_WB;
            end
            S_MEMORY: begin
                if (mem_ready) begin
                    if (dmem_error) begin
                        state_n = S_HALTED;
                        stat_n  = STAT_ADR;
                    end else begin
                        state_n = S_WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_n = S_HALTED;
                    stat_n  = STAT_ADR;
                end
            end
            S_WB: begin
                state_n = S_PCUPD;
            end
            S_PCUPD: begin
                state_n = run ? S_FETCH : S_IDLE;
            end
            S_HALTED: begin
                state_n = S_HALTED;
            end
        endcase
    end

    // Datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            PC          <= RESET_PC;
            stat        <= STAT_AOK;
            instr_count <= '0;
            icode_q     <= 4'h0;
            cnd_q       <= 1'b0;
            valm_q      <= 64'd0;
            wait_q      <= '0;
            dec_en      <= 1'b0;
            exe_en      <= 1'b0;
            wb_en       <= 1'b0;
            mem_req     <= 1'b0;
        end else begin
            stat    <= stat_n;
            dec_en  <= (state_n == S_DECODE);
            exe_en  <= (state_n == S_EXECUTE);
            wb_en   <= (state_n == S_WB);
            mem_req <= (state_n == S_MEMORY);

            if (state_q == S_DECODE) icode_q <= iCode;
            if (state_q == S_WB)     cnd_q   <= Cnd;
            if (state_q == S_MEMORY && mem_ready && !dmem_error) valm_q <= valM;

            if (state_q == S_MEMORY && state_n == S_MEMORY) begin
                wait_q <= wait_q + WAIT_W'(1);
            end else begin
                wait_q <= '0;
            end

            if (state_q == S_PCUPD) begin
                PC          <= next_pc_c;
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_y86_seq_controller.sv
// Directed self-checking bench for y86_seq_controller with hand-computed expectations.
module tb_y86_seq_controller;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned MEM_TO = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             run;
    logic [63:0]      PC;
    logic [3:0]       iCode;
    logic [63:0]      ValC;
    logic [63:0]      ValP;
    logic             Instr_Valid;
    logic             imem_error;
    logic             Cnd;
    logic [63:0]      valM;
    logic             dmem_error;
    logic             dec_en;
    logic             exe_en;
    logic             wb_en;
    logic             mem_req;
    logic             mem_ready;
    logic [2:0]       stat;
    logic [2:0]       state;
    logic [CNT_W-1:0] instr_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    y86_seq_controller #(
        .RESET_PC(64'd0),
        .CNT_W(CNT_W),
        .MEM_TIMEOUT(MEM_TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .PC(PC),
        .iCode(iCode), .ValC(ValC), .ValP(ValP), .Instr_Valid(Instr_Valid),
        .imem_error(imem_error), .Cnd(Cnd), .valM(valM), .dmem_error(dmem_error),
        .dec_en(dec_en), .exe_en(exe_en), .wb_en(wb_en), .mem_req(mem_req),
        .mem_ready(mem_ready), .stat(stat), .state(state), .instr_count(instr_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run = 1'b0;
        mem_ready = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_instr(input logic [3:0] ic, input logic [63:0] vc, input logic [63:0] vp,
                             input logic cnd, input logic valid, input logic ierr,
                             input logic derr, input logic [63:0] vm);
        iCode = ic; ValC = vc; ValP = vp; Cnd = cnd;
        Instr_Valid = valid; imem_error = ierr; dmem_error = derr; valM = vm;
    endtask

    // Runs one instruction from IDLE; logs {dec,exe,mem_req,wb} per cycle, one nibble each.
    task automatic exec_instr(input int ready_after, output int cycles, output int reqs,
                              output logic [63:0] en_log);
        cycles = 0;
        reqs = 0;
        en_log = 64'd0;
        run = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (state == 3'd7) break;
            if (cycles < 16) en_log[4*cycles +: 4] = {dec_en, exe_en, mem_req, wb_en};
            cycles++;
            if (mem_req) reqs++;
            mem_ready = mem_req && (reqs == ready_after + 1);
            if (state == 3'd6) begin
                run = 1'b0;
                mem_ready = 1'b0;
                tick();
                break;
            end
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        set_instr(4'h1, 64'h5, 64'h6, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
        do_reset();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        checks++; if (PC !== 64'd0) begin errors++; $display("FAIL reset_pc got %h want 0", PC); end
        checks++; if (stat !== 3'd1) begin errors++; $display("FAIL reset_stat got %0d want 1", stat); end
        checks++; if (instr_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", instr_count); end
        checks++; if ({dec_en, exe_en, wb_en, mem_req} !== 4'b0000) begin
            errors++; $display("FAIL reset_enables got %b want 0000", {dec_en, exe_en, wb_en, mem_req}); end
    endtask

    task automatic test_nop();
        int cyc; int req; logic [63:0] lg;
        set_instr(4'h1, 64'h0, 64'h1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
        exec_instr(0, cyc, req, lg);
        checks++; if (cyc !== 5) begin errors++; $display("FAIL nop_cycles got %0d want 5", cyc); end
        checks++; if (lg !== 64'h01480) begin errors++; $display("FAIL nop_enables got %h want 01480", lg); end
        checks++; if (req !== 0) begin errors++; $display("FAIL nop_memreq got %0d want 0", req); end
        checks++; if (PC !== 64'h1) begin errors++; $display("FAIL nop_pc got %h want 1", PC); end
        checks++; if (instr_count !== 4'd1) begin errors++; $display("FAIL nop_count got %0d want 1", instr_count); end
        checks++; if (stat !== 3'd1) begin errors++; $display("FAIL nop_stat got %0d want 1", stat); end
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL nop_idle got %0d want 0", state); end
    endtask

    task automatic test_jxx();
        int cyc; int req; logic [63:0] lg;
        set_instr(4'h7, 64'h40, 64'h9, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
        exec_instr(0, cyc, req, lg);
        checks++; if (PC !== 64'h9) begin errors++; $display("FAIL jxx_nt_pc got %h want 9", PC); end
        set_instr(4'h7, 64'h40, 64'h9, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
        exec_instr(0, cyc, req, lg);
        checks++; if (PC !== 64'h40) begin errors++; $display("FAIL jxx_t_pc got %h want 40", PC); end
        checks++; if (cyc !== 5) begin errors++; $display("FAIL jxx_cycles got %0d want 5", cyc); end
        checks++; if (instr_count !== 4'd3) begin errors++; $display("FAIL jxx_count got %0d want 3", instr_count); end
    endtask

    task automatic test_call();
        int cyc; int req; logic [63:0] lg;
        set_instr(4'h8, 64'h200, 64'h50, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
        exec_instr(0, cyc, req, lg);
        checks++; if (cyc !== 6) begin errors++; $display("FAIL call_cycles got %0d want 6", cyc); end
        checks++; if (req !== 1) begin errors++; $display("FAIL call_memreq got %0d want 1", req); end
        checks++; if (PC !== 64'h200) begin errors++; $display("FAIL call_pc got %h want 200", PC); end
    endtask

    task automatic test_ret();
        int cyc; int req; logic [63:0] lg;
        set_instr(4'h9, 64'h0, 64'h77, 1'b0, 1'b1, 1'b0, 1'b0, 64'h100);
        exec_instr(3, cyc, req, lg);
        checks++; if (cyc !== 9) begin errors++; $display("FAIL ret_cycles got %0d want 9", cyc); end
        checks++; if (req !== 4) begin errors++; $display("FAIL ret_memreq got %0d want 4", req); end
        checks++; if (lg !== 64'h012222480) begin errors++; $display("FAIL ret_enables got %h want 012222480", lg); end
        checks++; if (PC !== 64'h100) begin errors++; $display("FAIL ret_pc got %h want 100", PC); end
        checks++; if (instr_count !== 4'd5) begin errors++; $display("FAIL ret_count got %0d want 5", instr_count); end
    endtask

    task automatic test_timeout();
        int cyc; int req; logic [63:0] lg;
        set_instr(4'h5, 64'h0, 64'h33, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
        exec_instr(100, cyc, req, lg);
        checks++; if (req !== 4) begin errors++; $display("FAIL to_memreq got %0d want 4", req); end
        checks++; if (lg !== 64'h2222480) begin errors++; $display("FAIL to_enables got %h want 2222480", lg); end
        checks++; if (stat !== 3'd3) begin errors++; $display("FAIL to_stat got %0d want 3", stat); end
        checks++; if (state !== 3'd7) begin errors++; $display("FAIL to_state got %0d want 7", state); end
        checks++; if (PC !== 64'h100) begin errors++; $display("FAIL to_pc got %h want 100", PC); end
        checks++; if (instr_count !== 4'd5) begin errors++; $display("FAIL to_count got %0d want 5", instr_count); end
        for (int i = 0; i < 6; i++) begin
            run = i[0];
            tick();
        end
        run = 1'b0;
        checks++; if (state !== 3'd7) begin errors++; $display("FAIL halt_sticky got %0d want 7", state); end
        checks++; if ({dec_en, exe_en, wb_en, mem_req} !== 4'b0000) begin
            errors++; $display("FAIL halt_enables got %b want 0000", {dec_en, exe_en, wb_en, mem_req}); end
        checks++; if (PC !== 64'h100) begin errors++; $display("FAIL halt_pc got %h want 100", PC); end
    endtask

    task automatic test_reset_halted();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL rsth_state got %0d want 0", state); end
        checks++; if (PC !== 64'd0) begin errors++; $display("FAIL rsth_pc got %h want 0", PC); end
        checks++; if (stat !== 3'd1) begin errors++; $display("FAIL rsth_stat got %0d want 1", stat); end
        checks++; if (instr_count !== 4'd0) begin errors++; $display("FAIL rsth_count got %0d want 0", instr_count); end
    endtask

    task automatic test_faults();
        int cyc; int req; logic [63:0] lg;
        logic [3:0] f_ic[3]   = '{4'h1, 4'h0, 4'h1};
        logic       f_val[3]  = '{1'b0, 1'b1, 1'b0};
        logic       f_ierr[3] = '{1'b0, 1'b0, 1'b1};
        logic [2:0] f_stat[3] = '{3'd4, 3'd2, 3'd3};
        for (int k = 0; k < 3; k++) begin
            do_reset();
            set_instr(4'h1, 64'h0, 64'h1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
            exec_instr(0, cyc, req, lg);
            set_instr(f_ic[k], 64'h0, 64'h9, 1'b0, f_val[k], f_ierr[k], 1'b0, 64'h0);
            exec_instr(0, cyc, req, lg);
            checks++; if (stat !== f_stat[k]) begin errors++; $display("FAIL fault%0d_stat got %0d want %0d", k, stat, f_stat[k]); end
            checks++; if (state !== 3'd7) begin errors++; $display("FAIL fault%0d_state got %0d want 7", k, state); end
            checks++; if (instr_count !== 4'd1) begin errors++; $display("FAIL fault%0d_count got %0d want 1", k, instr_count); end
            checks++; if (PC !== 64'h1) begin errors++; $display("FAIL fault%0d_pc got %h want 1", k, PC); end
            checks++; if (lg !== 64'h80) begin errors++; $display("FAIL fault%0d_enables got %h want 80", k, lg); end
        end
    endtask

    task automatic test_dmem_error();
        int cyc; int req; logic [63:0] lg;
        do_reset();
        set_instr(4'h4, 64'h0, 64'ha, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0);
        exec_instr(1, cyc, req, lg);
        checks++; if (req !== 2) begin errors++; $display("FAIL dmem_memreq got %0d want 2", req); end
        checks++; if (stat !== 3'd3) begin errors++; $display("FAIL dmem_stat got %0d want 3", stat); end
        checks++; if (state !== 3'd7) begin errors++; $display("FAIL dmem_state got %0d want 7", state); end
        checks++; if (PC !== 64'h0) begin errors++; $display("FAIL dmem_pc got %h want 0", PC); end
    endtask

    task automatic test_reset_mem();
        int cyc; int req; logic [63:0] lg;
        do_reset();
        set_instr(4'h1, 64'h0, 64'h1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
        exec_instr(0, cyc, req, lg);
        set_instr(4'h9, 64'h0, 64'h2, 1'b0, 1'b1, 1'b0, 1'b0, 64'h300);
        run = 1'b1;
        repeat (4) tick();
        checks++; if ({state, mem_req} !== {3'd4, 1'b1}) begin
            errors++; $display("FAIL rstm_pre got %0d/%b want 4/1", state, mem_req); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        run = 1'b0;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL rstm_state got %0d want 0", state); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rstm_memreq got %b want 0", mem_req); end
        checks++; if (PC !== 64'd0) begin errors++; $display("FAIL rstm_pc got %h want 0", PC); end
        checks++; if (stat !== 3'd1) begin errors++; $display("FAIL rstm_stat got %0d want 1", stat); end
        checks++; if (instr_count !== 4'd0) begin errors++; $display("FAIL rstm_count got %0d want 0", instr_count); end
    endtask

    // Sixteen back-to-back nops with run held high wrap the 4-bit counter.
    task automatic test_back_to_back();
        do_reset();
        set_instr(4'h1, 64'h0, 64'h1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
        run = 1'b1;
        repeat (80) tick();
        checks++; if (state !== 3'd6) begin errors++; $display("FAIL b2b_state got %0d want 6", state); end
        checks++; if (instr_count !== 4'd15) begin errors++; $display("FAIL b2b_count15 got %0d want 15", instr_count); end
        tick();
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL b2b_refetch got %0d want 1", state); end
        checks++; if (instr_count !== 4'd0) begin errors++; $display("FAIL b2b_wrap got %0d want 0", instr_count); end
        run = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0;
        set_instr(4'h0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        test_reset();
        test_nop();
        test_jxx();
        test_call();
        test_ret();
        test_timeout();
        test_reset_halted();
        test_faults();
        test_dmem_error();
        test_reset_mem();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/y86_seq_controller.md
# y86_seq_controller

Stage sequencer for the sequential Y86-64 core. It owns the architectural PC and steps each instruction through FETCH, DECODE, EXECUTE, optional MEMORY, WRITEBACK and PC update, issuing one-cycle stage enables. It runs the data-memory request/ready handshake with a timeout and computes the next PC from the fetch-stage outputs (iCode, ValC, ValP), Cnd and valM. It raises the Y86 status code and freezes on halt, invalid instruction or address error.

## Interface
- RESET_PC, 64'd0, PC value loaded on reset
- CNT_W, 32, width of retired-instruction counter
- MEM_TIMEOUT, 16, max cycles mem_req may wait for mem_ready before ADR fault (>=1)

- clk  in  1  rising-edge clock, shared with fetch stage
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk
- run  in  1  leave IDLE and start the next instruction when high
- PC  out  64  current PC driven to fetch stage
- iCode  in  4  from fetch, registered
- ValC  in  64  from fetch
- ValP  in  64  from fetch
- Instr_Valid  in  1  from fetch
- imem_error  in  1  from fetch
- Cnd  in  1  branch/cmov condition from execute, valid in WRITEBACK
- valM  in  64  memory read data (return address for ret), valid with mem_ready
- dmem_error  in  1  data-memory fault, qualified by mem_ready
- dec_en, exe_en, wb_en  out  1 each  one-cycle stage enable pulses
- mem_req  out  1  held high in MEMORY until the handshake completes
- mem_ready  in  1  memory completion
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS
- state  out  3  encoded FSM state for debug
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

## Operation
- States: IDLE(0), FETCH(1), DECODE(2), EXECUTE(3), MEMORY(4), WRITEBACK(5), PCUPD(6), HALTED(7).
- IDLE: go to FETCH if run=1, else stay.
- FETCH: PC held stable; fetch registers its outputs at the end of this cycle. Always go to DECODE.
- DECODE: dec_en=1. Check fault priority: imem_error -> stat=ADR; else !Instr_Valid -> stat=INS; else iCode==0 -> stat=HLT. On any fault go to HALTED, with PC unchanged and instr_count unchanged. Otherwise go to EXECUTE.
- EXECUTE: exe_en=1. Go to MEMORY if iCode is in {4,5,8,9,A,B}, else to WRITEBACK.
- MEMORY: mem_req=1 with an internal wait counter. mem_ready=1 with dmem_error=0: latch valM, go to WRITEBACK. mem_ready=1 with dmem_error=1: stat=ADR, go to HALTED. Wait counter reaching MEM_TIMEOUT without mem_ready: stat=ADR, go to HALTED.
- WRITEBACK: wb_en=1. Go to PCUPD.
- PCUPD: load the new PC: iCode 7 -> Cnd?ValC:ValP; 8 -> ValC; 9 -> latched valM; otherwise ValP. instr_count +1. Go to FETCH if run=1, else IDLE.
- HALTED: terminal; all enables low; run is ignored; only reset exits.
- Cnd is sampled only in WRITEBACK and is registered for PCUPD.
- iCode is registered in DECODE; later stages use the registered copy.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, PC=RESET_PC, stat=AOK, instr_count=0, dec_en/exe_en/wb_en/mem_req=0, wait counter=0. Reset has priority in every state, including MEMORY (mem_req low in the cycle after the edge) and HALTED.
- All outputs are registered or decoded from state only; no combinational path from any input to any output.
- Non-memory instruction: 5 cycles FETCH->PCUPD. Memory instruction: 6+w cycles, where w = cycles mem_req waits before mem_ready (mem_ready in the first MEMORY cycle gives w=0).
- PC changes only on the edge leaving PCUPD or on reset.
- Timeout: if mem_ready has not arrived after MEM_TIMEOUT MEMORY cycles, the exit to HALTED occurs on that edge. mem_ready arriving in the timeout cycle counts as success.
- At most one enable or mem_req is high in any cycle.
- instr_count wraps from all-ones to 0 without flag.

## Test plan
- Reset then run=1, iCode=1 (nop), ValP=1: enables in order dec/exe/wb; PC=1 after 5 cycles; instr_count=1; stat=1; mem_req never asserted.
- iCode=7, ValC=0x40, ValP=9, Cnd=0 then repeat with Cnd=1: PC=9, then PC=0x40.
- iCode=9 (ret), mem_ready 3 cycles after mem_req, valM=0x100: mem_req high exactly 4 cycles; PC=0x100; total 9 cycles.
- MEM_TIMEOUT=4 with mem_ready stuck low: mem_req high 4 cycles; stat=3; state=7; PC unchanged; run toggling has no effect.
- Separate runs with Instr_Valid=0, with iCode=0, and with imem_error=1 plus Instr_Valid=0: stat=4, 2 and 3 respectively; instr_count unchanged.
- rst_n=0 during MEMORY and during HALTED: next cycle state=0, PC=RESET_PC, stat=1, mem_req=0, instr_count=0.
